cluster_pwr_seq: RTL and testbench

CLUSTER_PWR_SEQ -- requirements
Module: cluster_pwr_seq

---
 rtl/cluster_pwr_seq_pkg.sv | 19 +
 rtl/cluster_pwr_seq.sv | 156 +++++++++++++++
 tb/tb_cluster_pwr_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cluster_pwr_seq_pkg.sv
// Shared types and constants for the cluster power sequencer.
package cluster_pwr_seq_pkg;

  // Width of the dwell-time down-counter; bounds PWR_WAIT/RST_WAIT to 255.
  localparam int CNT_W = 8;

  // Sequencer states; encoding is visible on state_o.
  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWR_UP  = 3'd1,
    ST_CLK_EN  = 3'd2,
    ST_RST_REL = 3'd3,
    ST_RUN     = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_ISO     = 3'd6,
    ST_PWR_DN  = 3'd7
  } pwr_state_e;

endpackage

// File: rtl/cluster_pwr_seq.sv
// Cluster power sequencer: walks a cluster through power switch, clock
// enable and reset release on power-up, and back through drain and
// isolation on power-down. Requests arriving mid-transition are latched
// as pending and honoured once the opposite sequence completes.
module cluster_pwr_seq
  import cluster_pwr_seq_pkg::*;
#(
  parameter int PWR_WAIT = 16,
  parameter int RST_WAIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pwr_on_req_i,
  input  logic        pwr_off_req_i,
  input  logic [31:0] boot_addr_i,
  input  logic        fetch_en_cfg_i,
  input  logic        cluster_busy_i,
  output logic        cluster_pow_o,
  output logic        cluster_byp_o,
  output logic        cluster_clk_en_o,
  output logic        cluster_rstn_o,
  output logic        cluster_fetch_enable_o,
  output logic [63:0] cluster_boot_addr_o,
  output logic        evt_o,
  output logic [2:0]  state_o
);

  if (PWR_WAIT < 1 || PWR_WAIT > 255) begin : g_bad_pwr_wait
    $error("cluster_pwr_seq: PWR_WAIT must be in 1..255");
  end
  if (RST_WAIT < 1 || RST_WAIT > 255) begin : g_bad_rst_wait
    $error("cluster_pwr_seq: RST_WAIT must be in 1..255");
  end

  // Counter reload values: a state lasts WAIT cycles when loaded with WAIT-1.
  localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(PWR_WAIT - 1);
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_WAIT - 1);

  pwr_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             pend_on;
  logic             pend_off;
  logic [31:0]      boot_addr;
  logic             evt;

  // An on request is only meaningful without a competing off in the same cycle.
  logic on_only;
  assign on_only = pwr_on_req_i & ~pwr_off_req_i;

  // Sequencer state, dwell counter, pending flags, boot address and event pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_OFF;
      cnt       <= '0;
      pend_on   <= 1'b0;
      pend_off  <= 1'b0;
      boot_addr <= '0;
      evt       <= 1'b0;
    end else begin
      evt <= 1'b0;
      case (state)
        ST_OFF: begin
          if (on_only || pend_on) begin
            state     <= ST_PWR_UP;
            cnt       <= PWR_LOAD;
            pend_on   <= 1'b0;
            boot_addr <= boot_addr_i;
          end
        end
        ST_PWR_UP: begin
          if (pwr_off_req_i) pend_off <= 1'b1;
          if (cnt == '0) begin
            state <= ST_CLK_EN;
            cnt   <= RST_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_CLK_EN: begin
          if (pwr_off_req_i) pend_off <= 1'b1;
          if (cnt == '0) begin
            state <= ST_RST_REL;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RST_REL: begin
          if (pwr_off_req_i) pend_off <= 1'b1;
          state <= ST_RUN;
          evt   <= 1'b1;
        end
        ST_RUN: begin
          if (pwr_off_req_i || pend_off) begin
            state    <= ST_DRAIN;
            pend_off <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (on_only) pend_on <= 1'b1;
          if (!cluster_busy_i) state <= ST_ISO;
        end
        ST_ISO: begin
          if (on_only) pend_on <= 1'b1;
          state <= ST_PWR_DN;
          cnt   <= PWR_LOAD;
        end
        ST_PWR_DN: begin
          if (on_only) pend_on <= 1'b1;
          if (cnt == '0) begin
            state <= ST_OFF;
            evt   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // Moore decode of cluster controls from the registered state.
  always_comb begin
    cluster_pow_o          = 1'b1;
    cluster_byp_o          = 1'b0;
    cluster_clk_en_o       = 1'b0;
    cluster_rstn_o         = 1'b0;
    cluster_fetch_enable_o = 1'b0;
    case (state)
      ST_OFF: begin
        cluster_pow_o = 1'b0;
        cluster_byp_o = 1'b1;
      end
      ST_PWR_UP, ST_PWR_DN: begin
        cluster_byp_o = 1'b1;
      end
      ST_CLK_EN: begin
        cluster_clk_en_o = 1'b1;
      end
      ST_RST_REL, ST_DRAIN: begin
        cluster_clk_en_o = 1'b1;
        cluster_rstn_o   = 1'b1;
      end
      ST_RUN: begin
        cluster_clk_en_o       = 1'b1;
        cluster_rstn_o         = 1'b1;
        cluster_fetch_enable_o = fetch_en_cfg_i;
      end
      default: begin
      end
    endcase
  end

  assign cluster_boot_addr_o = {32'h0, boot_addr};
  assign evt_o               = evt;
  assign state_o             = state;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Directed bench for cluster_pwr_seq at default parameters.
module tb_cluster_pwr_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        pwr_on_req_i = 1'b0;
  logic        pwr_off_req_i = 1'b0;
  logic [31:0] boot_addr_i = '0;
  logic        fetch_en_cfg_i = 1'b1;
  logic        cluster_busy_i = 1'b0;
  logic        cluster_pow_o;
  logic        cluster_byp_o;
  logic        cluster_clk_en_o;
  logic        cluster_rstn_o;
  logic        cluster_fetch_enable_o;
  logic [63:0] cluster_boot_addr_o;
  logic        evt_o;
  logic [2:0]  state_o;

  int compared = 0;
  int mismatched = 0;

  // {state, pow, byp, clk_en, rstn, fetch_enable, evt}
  logic [8:0] obs;
  assign obs = {state_o, cluster_pow_o, cluster_byp_o, cluster_clk_en_o,
                cluster_rstn_o, cluster_fetch_enable_o, evt_o};

  cluster_pwr_seq dut (
    .clk_i                  (clk_i),
    .rst_ni                 (rst_ni),
    .pwr_on_req_i           (pwr_on_req_i),
    .pwr_off_req_i          (pwr_off_req_i),
    .boot_addr_i            (boot_addr_i),
    .fetch_en_cfg_i         (fetch_en_cfg_i),
    .cluster_busy_i         (cluster_busy_i),
    .cluster_pow_o          (cluster_pow_o),
    .cluster_byp_o          (cluster_byp_o),
    .cluster_clk_en_o       (cluster_clk_en_o),
    .cluster_rstn_o         (cluster_rstn_o),
    .cluster_fetch_enable_o (cluster_fetch_enable_o),
    .cluster_boot_addr_o    (cluster_boot_addr_o),
    .evt_o                  (evt_o),
    .state_o                (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Brings the cluster from OFF to RUN; leaves it one cycle after RUN entry.
  task automatic do_power_up(input logic [31:0] addr);
    boot_addr_i  = addr;
    pwr_on_req_i = 1'b1;
    step();
    pwr_on_req_i = 1'b0;
    repeat (26) step();
  endtask

  // From RUN with the cluster idle: DRAIN, ISO, 16 x PWR_DN, then OFF.
  task automatic do_power_down();
    cluster_busy_i = 1'b0;
    pwr_off_req_i  = 1'b1;
    step();
    pwr_off_req_i = 1'b0;
    repeat (19) step();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #2;
    compared++;
    if ({obs, cluster_boot_addr_o} !== {9'b000_010000, 64'h0}) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b/%h want %b/%h", obs, cluster_boot_addr_o,
               9'b000_010000, 64'h0);
    end
    step();
    rst_ni = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      step();
      compared++;
      if (obs !== 9'b000_010000) begin
        mismatched++;
        $display("FAIL reset_release_c%0d: got %b want %b", n, obs, 9'b000_010000);
      end
    end
  endtask

  task automatic test_power_up();
    boot_addr_i    = 32'h1C008080;
    fetch_en_cfg_i = 1'b1;
    pwr_on_req_i   = 1'b1;
    for (int n = 1; n <= 27; n++) begin
      logic [8:0] exp;
      logic       chk;
      step();
      if (n == 1) begin
        pwr_on_req_i = 1'b0;
        boot_addr_i  = 32'hDEADBEEF;
      end
      chk = 1'b1;
      case (n)
        1:  exp = 9'b001_110000;
        16: exp = 9'b001_110000;
        17: exp = 9'b010_101000;
        24: exp = 9'b010_101000;
        25: exp = 9'b011_101100;
        26: exp = 9'b100_101111;
        27: exp = 9'b100_101110;
        default: begin exp = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        compared++;
        if (obs !== exp) begin
          mismatched++;
          $display("FAIL power_up_c%0d: got %b want %b", n, obs, exp);
        end
      end
    end
    compared++;
    if (cluster_boot_addr_o !== 64'h000000001C008080) begin
      mismatched++;
      $display("FAIL power_up_boot_addr: got %h want %h", cluster_boot_addr_o,
               64'h000000001C008080);
    end
  endtask

  task automatic test_power_down();
    pwr_off_req_i  = 1'b1;
    cluster_busy_i = 1'b1;
    for (int n = 1; n <= 29; n++) begin
      logic [8:0] exp;
      logic       chk;
      step();
      if (n == 1) pwr_off_req_i = 1'b0;
      chk = 1'b1;
      case (n)
        1:  exp = 9'b101_101100;
        10: exp = 9'b101_101100;
        11: exp = 9'b110_100000;
        12: exp = 9'b111_110000;
        27: exp = 9'b111_110000;
        28: exp = 9'b000_010001;
        29: exp = 9'b000_010000;
        default: begin exp = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        compared++;
        if (obs !== exp) begin
          mismatched++;
          $display("FAIL power_down_c%0d: got %b want %b", n, obs, exp);
        end
      end
      if (n == 10) cluster_busy_i = 1'b0;
    end
  endtask

  task automatic test_early_off();
    boot_addr_i  = 32'h00001000;
    pwr_on_req_i = 1'b1;
    for (int n = 1; n <= 46; n++) begin
      logic [8:0] exp;
      logic       chk;
      step();
      if (n == 1) pwr_on_req_i = 1'b0;
      if (n == 5) pwr_off_req_i = 1'b1;
      if (n == 6) pwr_off_req_i = 1'b0;
      chk = 1'b1;
      case (n)
        6:  exp = 9'b001_110000;
        25: exp = 9'b011_101100;
        26: exp = 9'b100_101111;
        27: exp = 9'b101_101100;
        28: exp = 9'b110_100000;
        45: exp = 9'b000_010001;
        46: exp = 9'b000_010000;
        default: begin exp = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        compared++;
        if (obs !== exp) begin
          mismatched++;
          $display("FAIL early_off_c%0d: got %b want %b", n, obs, exp);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    pwr_on_req_i  = 1'b1;
    pwr_off_req_i = 1'b1;
    step();
    pwr_on_req_i  = 1'b0;
    pwr_off_req_i = 1'b0;
    compared++;
    if (obs !== 9'b000_010000) begin
      mismatched++;
      $display("FAIL simul_off_c1: got %b want %b", obs, 9'b000_010000);
    end
    step();
    compared++;
    if (obs !== 9'b000_010000) begin
      mismatched++;
      $display("FAIL simul_off_c2: got %b want %b", obs, 9'b000_010000);
    end
    do_power_up(32'hABCD0000);
    pwr_on_req_i  = 1'b1;
    pwr_off_req_i = 1'b1;
    for (int n = 1; n <= 21; n++) begin
      logic [8:0] exp;
      logic       chk;
      step();
      if (n == 1) begin
        pwr_on_req_i  = 1'b0;
        pwr_off_req_i = 1'b0;
      end
      chk = 1'b1;
      case (n)
        1:  exp = 9'b101_101100;
        2:  exp = 9'b110_100000;
        19: exp = 9'b000_010001;
        20: exp = 9'b000_010000;
        21: exp = 9'b000_010000;
        default: begin exp = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        compared++;
        if (obs !== exp) begin
          mismatched++;
          $display("FAIL simul_run_c%0d: got %b want %b", n, obs, exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    boot_addr_i  = 32'h55AA55AA;
    pwr_on_req_i = 1'b1;
    step();
    pwr_on_req_i = 1'b0;
    repeat (19) step();
    compared++;
    if (obs !== 9'b010_101000) begin
      mismatched++;
      $display("FAIL reset_mid_pre: got %b want %b", obs, 9'b010_101000);
    end
    rst_ni = 1'b0;
    #1;
    compared++;
    if ({obs, cluster_boot_addr_o} !== {9'b000_010000, 64'h0}) begin
      mismatched++;
      $display("FAIL reset_mid_async: got %b/%h want %b/%h", obs, cluster_boot_addr_o,
               9'b000_010000, 64'h0);
    end
    step();
    rst_ni = 1'b1;
    step();
    compared++;
    if (obs !== 9'b000_010000) begin
      mismatched++;
      $display("FAIL reset_mid_after: got %b want %b", obs, 9'b000_010000);
    end
  endtask

  task automatic test_pending_on();
    do_power_up(32'h10000000);
    cluster_busy_i = 1'b0;
    pwr_off_req_i  = 1'b1;
    for (int n = 1; n <= 46; n++) begin
      logic [8:0] exp;
      logic       chk;
      step();
      if (n == 1) pwr_off_req_i = 1'b0;
      if (n == 5) begin
        pwr_on_req_i = 1'b1;
        boot_addr_i  = 32'h11110000;
      end
      if (n == 6) pwr_on_req_i = 1'b0;
      if (n == 19) boot_addr_i = 32'h33330000;
      chk = 1'b1;
      case (n)
        6:  exp = 9'b111_110000;
        19: exp = 9'b000_010001;
        20: exp = 9'b001_110000;
        36: exp = 9'b010_101000;
        45: exp = 9'b100_101111;
        46: exp = 9'b100_101110;
        default: begin exp = '0; chk = 1'b0; end
      endcase
      if (chk) begin
        compared++;
        if (obs !== exp) begin
          mismatched++;
          $display("FAIL pending_on_c%0d: got %b want %b", n, obs, exp);
        end
      end
      if (n == 20) begin
        compared++;
        if (cluster_boot_addr_o !== 64'h0000000033330000) begin
          mismatched++;
          $display("FAIL pending_on_boot_addr: got %h want %h", cluster_boot_addr_o,
                   64'h0000000033330000);
        end
      end
    end
  endtask

  task automatic test_redundant();
    fetch_en_cfg_i = 1'b0;
    pwr_on_req_i   = 1'b1;
    step();
    pwr_on_req_i = 1'b0;
    step();
    compared++;
    if (obs !== 9'b100_101100) begin
      mismatched++;
      $display("FAIL redundant_on_run: got %b want %b", obs, 9'b100_101100);
    end
    fetch_en_cfg_i = 1'b1;
    do_power_down();
    compared++;
    if (obs !== 9'b000_010000) begin
      mismatched++;
      $display("FAIL redundant_pd_done: got %b want %b", obs, 9'b000_010000);
    end
    pwr_off_req_i = 1'b1;
    step();
    pwr_off_req_i = 1'b0;
    step();
    compared++;
    if (obs !== 9'b000_010000) begin
      mismatched++;
      $display("FAIL redundant_off_off: got %b want %b", obs, 9'b000_010000);
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_early_off();
    test_simultaneous();
    test_reset_mid();
    test_pending_on();
    test_redundant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
